arm_reg_file: RTL and testbench

//  ARM general-purpose register file: the consumer end of the MEM/WB pipeline register.

---
 rtl/arm_rf_pkg.sv | 19 +
 rtl/rf_pend_counter.sv | 50 +++++
 rtl/arm_reg_file.sv | 103 ++++++++++
 tb/tb_arm_reg_file.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_rf_pkg.sv
// Shared constants and types for the ARM general-purpose register file.
// Included by the register file top and by its pending-write counters.
package arm_rf_pkg;

  localparam int DW       = 32;
  localparam int AW       = 4;
  localparam int CNT_W    = 2;
  localparam int NUM_REGS = 15;

  typedef logic [AW-1:0] reg_idx_t;

  localparam reg_idx_t REG_PC = 4'd15;

  // Number of retiring events (write-back, squash) that hit one register in a cycle.
  function automatic logic [1:0] hit_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/rf_pend_counter.sv
// Saturating up/down counter of in-flight writers for one register.
// ovf/udf flag the cycle in which the net update would leave the counter range.
module rf_pend_counter
  import arm_rf_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic [1:0]   dec,
  output logic [W-1:0] cnt,
  output logic         ovf,
  output logic         udf
);

  localparam int MAX = (1 << W) - 1;

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;
  int           sum;

  // Net update is evaluated in full precision, then clamped to the counter range.
  always_comb begin
    sum      = int'(cnt_reg) + int'(inc) - int'(dec);
    cnt_next = cnt_reg;
    ovf      = 1'b0;
    udf      = 1'b0;
    if (sum > MAX) begin
      cnt_next = W'(MAX);
      ovf      = 1'b1;
    end else if (sum < 0) begin
      cnt_next = '0;
      udf      = 1'b1;
    end else begin
      cnt_next = W'(sum);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/arm_reg_file.sv
// ARM GPR file R0..R14 with write-through read bypass and a per-register
// pending-writer scoreboard feeding the hazard unit.
module arm_reg_file
  import arm_rf_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_dest,
  input  logic [DW-1:0] wb_value,
  input  logic [AW-1:0] src1,
  input  logic [AW-1:0] src2,
  output logic [DW-1:0] reg1,
  output logic [DW-1:0] reg2,
  input  logic          issue_en,
  input  logic [AW-1:0] issue_dest,
  input  logic          kill_en,
  input  logic [AW-1:0] kill_dest,
  output logic          busy1,
  output logic          busy2,
  output logic          sb_err
);

  localparam int IDX_N = 1 << AW;

  logic [DW-1:0]       rf_q   [IDX_N];
  logic [CNT_W-1:0]    pend_q [IDX_N];
  logic [NUM_REGS-1:0] ovf_vec;
  logic [NUM_REGS-1:0] udf_vec;
  logic                sb_err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < IDX_N; gi++) begin : g_reg
      if (gi < NUM_REGS) begin : g_impl
        logic          wb_hit;
        logic          kill_hit;
        logic          issue_hit;
        logic [DW-1:0] data_reg;

        assign wb_hit    = wb_en    && (wb_dest    == AW'(gi));
        assign kill_hit  = kill_en  && (kill_dest  == AW'(gi));
        assign issue_hit = issue_en && (issue_dest == AW'(gi));

        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            data_reg <= '0;
          end else if (wb_hit) begin
            data_reg <= wb_value;
          end
        end

        assign rf_q[gi] = data_reg;

        rf_pend_counter #(.W(CNT_W)) u_pend (
          .clk (clk),
          .rst (rst),
          .inc (issue_hit),
          .dec (hit_count(wb_hit, kill_hit)),
          .cnt (pend_q[gi]),
          .ovf (ovf_vec[gi]),
          .udf (udf_vec[gi])
        );
      end else begin : g_pc
        // PC lives outside the file: reads as zero and is never tracked.
        assign rf_q[gi]   = '0;
        assign pend_q[gi] = '0;
      end
    end
  endgenerate

  // A writer retiring this cycle is served by the bypass, so it no longer counts as busy.
  always_comb begin
    reg1  = '0;
    busy1 = 1'b0;
    if (rst && (src1 != REG_PC)) begin
      reg1  = (wb_en && (wb_dest == src1)) ? wb_value : rf_q[src1];
      busy1 = int'(pend_q[src1]) !=
              int'(hit_count(wb_en && (wb_dest == src1), kill_en && (kill_dest == src1)));
    end
  end

  always_comb begin
    reg2  = '0;
    busy2 = 1'b0;
    if (rst && (src2 != REG_PC)) begin
      reg2  = (wb_en && (wb_dest == src2)) ? wb_value : rf_q[src2];
      busy2 = int'(pend_q[src2]) !=
              int'(hit_count(wb_en && (wb_dest == src2), kill_en && (kill_dest == src2)));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_err_reg <= 1'b0;
    end else if ((|ovf_vec) || (|udf_vec)) begin
      sb_err_reg <= 1'b1;
    end
  end

  assign sb_err = sb_err_reg;

endmodule

// File: tb/tb_arm_reg_file.sv
// Testbench for arm_reg_file: directed scenarios plus random traffic, with
// expected outputs queued by the driver and compared by an independent monitor.
module tb_arm_reg_file;
  import arm_rf_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wb_en = 1'b0;
  logic [AW-1:0] wb_dest = '0;
  logic [DW-1:0] wb_value = '0;
  logic [AW-1:0] src1 = '0;
  logic [AW-1:0] src2 = '0;
  logic [DW-1:0] reg1;
  logic [DW-1:0] reg2;
  logic          issue_en = 1'b0;
  logic [AW-1:0] issue_dest = '0;
  logic          kill_en = 1'b0;
  logic [AW-1:0] kill_dest = '0;
  logic          busy1;
  logic          busy2;
  logic          sb_err;

  always #5 clk = ~clk;

  arm_reg_file dut (
    .clk        (clk),
    .rst        (rst),
    .wb_en      (wb_en),
    .wb_dest    (wb_dest),
    .wb_value   (wb_value),
    .src1       (src1),
    .src2       (src2),
    .reg1       (reg1),
    .reg2       (reg2),
    .issue_en   (issue_en),
    .issue_dest (issue_dest),
    .kill_en    (kill_en),
    .kill_dest  (kill_dest),
    .busy1      (busy1),
    .busy2      (busy2),
    .sb_err     (sb_err)
  );

  typedef struct {
    string       name;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        b1;
    logic        b2;
    logic        err;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Reference model: register values, writer counts as plain integers, sticky error bit.
  logic [31:0] m_rf   [15];
  int          m_pend [15];
  bit          m_err;

  function automatic void model_clear();
    for (int r = 0; r < 15; r++) begin
      m_rf[r]   = 32'h0;
      m_pend[r] = 0;
    end
    m_err = 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] s);
    if (s == 4'd15) return 32'h0;
    if (wb_en && wb_dest == s) return wb_value;
    return m_rf[s];
  endfunction

  function automatic logic m_busy(input logic [3:0] s);
    int n;
    if (s == 4'd15) return 1'b0;
    n = m_pend[s];
    if (wb_en && wb_dest == s) n = n - 1;
    if (kill_en && kill_dest == s) n = n - 1;
    return n != 0;
  endfunction

  function automatic void model_edge();
    int n;
    if (!rst) return;
    for (int r = 0; r < 15; r++) begin
      n = m_pend[r];
      if (issue_en && issue_dest == 4'(r)) n = n + 1;
      if (wb_en && wb_dest == 4'(r)) n = n - 1;
      if (kill_en && kill_dest == 4'(r)) n = n - 1;
      if (n > 3) begin
        n = 3;
        m_err = 1'b1;
      end else if (n < 0) begin
        n = 0;
        m_err = 1'b1;
      end
      m_pend[r] = n;
    end
    if (wb_en && wb_dest != 4'd15) m_rf[wb_dest] = wb_value;
  endfunction

  // Called just after a falling edge with inputs already applied.
  task automatic cyc(input string name);
    exp_t e;
    if (!rst) model_clear();
    e.name = name;
    e.r1   = rst ? m_read(src1) : 32'h0;
    e.r2   = rst ? m_read(src2) : 32'h0;
    e.b1   = rst ? m_busy(src1) : 1'b0;
    e.b2   = rst ? m_busy(src2) : 1'b0;
    e.err  = m_err;
    q.push_back(e);
    ->chk_ev;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    wb_en    = 1'b0;
    issue_en = 1'b0;
    kill_en  = 1'b0;
  endtask

  task automatic cmp(input string n, input string f, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s got=%h exp=%h", n, f, got, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      #2;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL queue_empty got=0 entries exp>=1");
      end else begin
        e = q.pop_front();
        txn++;
        cmp(e.name, "reg1",   reg1,           e.r1);
        cmp(e.name, "reg2",   reg2,           e.r2);
        cmp(e.name, "busy1",  32'(busy1),     32'(e.b1));
        cmp(e.name, "busy2",  32'(busy2),     32'(e.b2));
        cmp(e.name, "sb_err", 32'(sb_err),    32'(e.err));
        $display("txn %0d %s src=%0d/%0d reg1=%h reg2=%h busy=%b%b sb_err=%b",
                 txn, e.name, src1, src2, reg1, reg2, busy1, busy2, sb_err);
      end
    end
  end

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    src1 = 4'd0; src2 = 4'd14;
    cyc("post_reset");

    // Write R1..R4, leave R1 with an outstanding writer, then reset asynchronously.
    for (int i = 1; i <= 4; i++) begin
      wb_en = 1'b1; wb_dest = 4'(i); wb_value = 32'hA000_0000 + 32'(i);
      cyc("t1_write");
    end
    idle();
    issue_en = 1'b1; issue_dest = 4'd1;
    cyc("t1_issue");
    idle();
    src1 = 4'd1; src2 = 4'd4;
    cyc("t1_readback");
    rst = 1'b0;
    wb_en = 1'b1; wb_dest = 4'd1; wb_value = 32'h5555_AAAA;
    cyc("t1_reset_low");
    idle();
    rst = 1'b1;
    cyc("t1_after_reset");

    // Write-through bypass, then the stored value.
    wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'hDEADBEEF; src1 = 4'd3; src2 = 4'd15;
    cyc("t2_bypass");
    idle();
    cyc("t2_stored");

    // Writes to the PC index are dropped and it always reads zero.
    wb_en = 1'b1; wb_dest = 4'd15; wb_value = 32'h1234; src1 = 4'd15; src2 = 4'd3;
    cyc("t3_pc_write");
    idle();
    cyc("t3_pc_next");
    for (int i = 0; i < 15; i++) begin
      src1 = 4'(i); src2 = 4'(14 - i);
      cyc("t3_scan");
    end

    // Two writers to R5 retire one at a time.
    issue_en = 1'b1; issue_dest = 4'd5; src1 = 4'd5; src2 = 4'd0;
    cyc("t4_issue_a");
    cyc("t4_issue_b");
    idle();
    cyc("t4_pend2");
    wb_en = 1'b1; wb_dest = 4'd5; wb_value = 32'h0000_0055;
    cyc("t4_wb_first");
    wb_value = 32'h0000_0555;
    cyc("t4_wb_second");
    idle();
    cyc("t4_idle");

    // Issue and retire to the same register in one cycle.
    issue_en = 1'b1; issue_dest = 4'd2; src1 = 4'd2;
    cyc("t5_issue");
    wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'h2222_0002;
    cyc("t5_issue_wb");
    idle();
    cyc("t5_next");
    wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'h2222_0003;
    cyc("t5_drain");
    idle();

    // Overflow on R7, then underflow on R8 after a reset.
    issue_en = 1'b1; issue_dest = 4'd7; src1 = 4'd7; src2 = 4'd8;
    for (int i = 0; i < 4; i++) cyc("t6_issue7");
    idle();
    cyc("t6_ovf_err");
    rst = 1'b0;
    cyc("t6_reset");
    rst = 1'b1;
    src1 = 4'd8;
    wb_en = 1'b1; wb_dest = 4'd8; wb_value = 32'h8888_8888;
    cyc("t6_wb8_empty");
    idle();
    cyc("t6_udf_err");

    // Random traffic with occasional mid-operation resets.
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 63) != 0);
      wb_en      = $urandom_range(0, 1) == 1;
      wb_dest    = 4'($urandom_range(0, 15));
      wb_value   = $urandom;
      issue_en   = $urandom_range(0, 1) == 1;
      issue_dest = 4'($urandom_range(0, 15));
      kill_en    = $urandom_range(0, 7) == 0;
      kill_dest  = 4'($urandom_range(0, 15));
      src1       = 4'($urandom_range(0, 15));
      src2       = ($urandom_range(0, 3) == 0) ? wb_dest : 4'($urandom_range(0, 15));
      cyc("rand");
    end
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d entries exp=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
